wb_store_queue: RTL and testbench
=================================

WB_STORE_QUEUE -- requirements
Module: wb_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  writeback store push, driven by writeback mem_ld.
REQ-005 SHALL have port wr_addr  input  32  store address.
REQ-006 SHALL have port wr_data  input  64  store data, little-endian, low bytes valid per size.
REQ-007 SHALL have port wr_size  input  2  00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 SHALL have port full  output  1  count==DEPTH, to writeback wbaq_full.
REQ-009 SHALL have port empty  output  1  count==0, for halt/interrupt serialization.
REQ-010 SHALL have port count  output  4  occupied entries.
REQ-011 SHALL have port dc_req  output  1  dcache write request.
REQ-012 SHALL have ports dc_addr/dc_data/dc_size  output  32/64/2  head-entry payload.
REQ-013 SHALL have port dc_ack  input  1  dcache accepts current request.
REQ-014 SHALL have port ovf_err  output  1  sticky push-while-full error.
REQ-015 SHALL have ports fwd_addr input 32 and fwd_hit output 1  load-vs-store match probe.

Function
REQ-016 SHALL be a circular FIFO with head/tail pointers mod DEPTH plus count register.
REQ-017 SHALL push {wr_addr,wr_data,wr_size} at tail on edge where wr_en=1 and full=0 (pre-edge value).
REQ-018 SHALL ignore push when full=1 and set ovf_err; queue contents unchanged.
REQ-019 SHALL run drain FSM states IDLE, REQ; dc_req=1 only in REQ.
REQ-020 SHALL go IDLE->REQ on any edge where empty=0; dc_req first visible the cycle after the first push edge.
REQ-021 SHALL hold dc_addr/dc_data/dc_size equal to head entry and stable while dc_req=1 and dc_ack=0.
REQ-022 SHALL pop head on edge where state=REQ and dc_ack=1; one write per ack.
REQ-023 SHALL stay in REQ after pop if count after pop >0 (back-to-back, next head presented next cycle), else go IDLE.
REQ-024 SHALL ignore dc_ack while in IDLE.
REQ-025 SHALL, on simultaneous accepted push and pop, keep count unchanged and advance both pointers.
REQ-026 SHALL not accept push into a slot being popped when full=1 in same cycle (full is sampled pre-edge).
REQ-027 SHALL wrap head/tail from DEPTH-1 to 0 with no gap or duplicate.
REQ-028 SHALL drive full, empty, count combinationally from registered count only.
REQ-029 SHALL drive dc_addr/dc_data/dc_size to 0 when dc_req=0.

Reset
REQ-030 SHALL, on rst=1 at clock edge, clear head, tail, count, ovf_err, set FSM IDLE, discarding all entries.
REQ-031 SHALL after reset present dc_req=0, full=0, empty=1, count=0, ovf_err=0, fwd_hit=0.
REQ-032 SHALL give rst priority over concurrent wr_en and dc_ack, including mid-request (request dropped).

Configuration
REQ-033 SHALL, with WBSQ_FORWARD_EN defined, drive fwd_hit=1 combinationally when any occupied entry has addr[31:3]==fwd_addr[31:3].
REQ-034 SHALL, without WBSQ_FORWARD_EN, tie fwd_hit=0, omit comparators, keep port list identical.

Verification
REQ-035 SHALL cover: push addr=0x1000 data=0xAA size=00, dc_ack held 0 -> dc_req=1 next cycle, dc_addr=0x1000 stable 5 cycles, count=1.
REQ-036 SHALL cover: 4 pushes, no ack -> full=1 count=4; 5th push -> ignored, ovf_err=1 sticky, count=4.
REQ-037 SHALL cover: full queue, dc_ack=1 four consecutive cycles -> 4 writes in push order, dc_req=0 after, empty=1.
REQ-038 SHALL cover: count=2, push and ack same edge -> count=2, head advanced, 7 pushes/7 acks total exercise pointer wrap with correct order.
REQ-039 SHALL cover: rst=1 while dc_req=1 count=3 -> next cycle dc_req=0 count=0 empty=1 ovf_err=0.
REQ-040 SHALL cover: WBSQ_FORWARD_EN on, entry addr 0x2004, fwd_addr=0x2000 -> fwd_hit=1; fwd_addr=0x2008 -> 0; macro off -> always 0.

Source files
------------

// File: rtl/wb_store_queue_if.sv
// ----------------------------------------------------------------------------
// wb_store_queue_if
// Bundles every non-clock/reset signal of wb_store_queue.
//
// Signal groups:
//   push side  : wr_en, wr_addr[31:0], wr_data[63:0], wr_size[1:0]
//   status     : full, empty, count[3:0], ovf_err
//   dcache side: dc_req, dc_addr[31:0], dc_data[63:0], dc_size[1:0], dc_ack
//   forwarding : fwd_addr[31:0] (probe), fwd_hit
//   debug      : dbg_state (0 = IDLE, 1 = REQ)
//
// Modports:
//   slave  - the store queue itself
//   master - the surrounding pipeline / dcache / bench
// ----------------------------------------------------------------------------
interface wb_store_queue_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_size;

    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        ovf_err;

    logic        dc_req;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic [1:0]  dc_size;
    logic        dc_ack;

    logic [31:0] fwd_addr;
    logic        fwd_hit;

    logic        dbg_state;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_size, dc_ack, fwd_addr,
        output full, empty, count, ovf_err,
        output dc_req, dc_addr, dc_data, dc_size, fwd_hit, dbg_state
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_size, dc_ack, fwd_addr,
        input  full, empty, count, ovf_err,
        input  dc_req, dc_addr, dc_data, dc_size, fwd_hit, dbg_state
    );
endinterface

// File: rtl/wb_store_queue.sv
// ----------------------------------------------------------------------------
// wb_store_queue
// Writeback store queue: buffers committed stores in a circular FIFO and
// drains them one at a time into the dcache.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset; discards all entries
//   bus  - wb_store_queue_if.slave (push side, status, dcache side,
//          forwarding probe, debug state)
//
// Parameters:
//   DEPTH - number of entries, power of two in 2..8
//
// Optional feature macro:
//   WBSQ_FORWARD_EN - when defined, fwd_hit reports whether any occupied
//                     entry lies in the same 8-byte block as fwd_addr.
//                     When undefined, fwd_hit is tied low.
//
// Handshake:
//   Push: a store is accepted on a rising edge where wr_en=1 and full=0
//   (full as seen before the edge). A push while full is dropped and sets
//   the sticky ovf_err.
//   Drain: dc_req is the valid, dc_ack the ready. A write completes on a
//   rising edge with dc_req=1 and dc_ack=1; payload is held stable while
//   dc_req=1 and dc_ack=0. dc_ack while dc_req=0 has no effect.
// ----------------------------------------------------------------------------
module wb_store_queue #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    wb_store_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [3:0]    cnt;
    logic [3:0]    cnt_n;
    logic          push_acc;
    logic          pop;
    logic          ovf_q;

    logic [31:0]   mem_addr [DEPTH];
    logic [63:0]   mem_data [DEPTH];
    logic [1:0]    mem_size [DEPTH];

    // Status comes straight from the count register.
    assign bus.full    = (cnt == DEPTH_C);
    assign bus.empty   = (cnt == 4'd0);
    assign bus.count   = cnt;
    assign bus.ovf_err = ovf_q;

    assign push_acc = bus.wr_en && !bus.full;
    assign pop      = (state == S_REQ) && bus.dc_ack;
    assign cnt_n    = cnt + {3'b000, push_acc} - {3'b000, pop};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (cnt != 4'd0) state_n = S_REQ;
            // Stay in REQ for back-to-back drains; leave only once the
            // queue is empty after this edge (a same-edge push keeps us here).
            S_REQ:  if (pop && (cnt_n == 4'd0)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.dc_req    = 1'b0;
        bus.dc_addr   = 32'd0;
        bus.dc_data   = 64'd0;
        bus.dc_size   = 2'd0;
        bus.dbg_state = state;
        if (state == S_REQ) begin
            bus.dc_req  = 1'b1;
            bus.dc_addr = mem_addr[head];
            bus.dc_data = mem_data[head];
            bus.dc_size = mem_size[head];
        end
    end

    // ---------------- pointers, count, error flag ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push_acc) tail <= tail + PW'(1);
            if (pop)      head <= head + PW'(1);
            cnt <= cnt_n;
            if (bus.wr_en && bus.full) ovf_q <= 1'b1;
        end
    end

    // ---------------- entry storage ----------------
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_addr[tail] <= bus.wr_addr;
            mem_data[tail] <= bus.wr_data;
            mem_size[tail] <= bus.wr_size;
        end
    end

    // ---------------- store-to-load forwarding probe ----------------
`ifdef WBSQ_FORWARD_EN
    logic [PW-1:0]    slot_off;
    logic [DEPTH-1:0] occ;
    logic             unused_fwd_lo;

    // Slot i is occupied when its distance from head is below count.
    always_comb begin
        occ      = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - head;
            occ[i]   = ({{(4-PW){1'b0}}, slot_off} < cnt);
        end
    end

    always_comb begin
        bus.fwd_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (mem_addr[i][31:3] == bus.fwd_addr[31:3])) begin
                bus.fwd_hit = 1'b1;
            end
        end
    end

    // Byte offset within the 8-byte block does not affect a match.
    assign unused_fwd_lo = ^bus.fwd_addr[2:0];
`else
    logic unused_fwd;

    assign bus.fwd_hit = 1'b0;
    assign unused_fwd  = ^bus.fwd_addr;
`endif

endmodule

// File: tb/tb_wb_store_queue.sv
// ----------------------------------------------------------------------------
// tb_wb_store_queue
// Directed bench for wb_store_queue (DEPTH=4). Each accepted push records
// the expected dcache write in exp_q; a negedge monitor pops and compares
// whenever a write handshake (dc_req && dc_ack) is presented.
// ----------------------------------------------------------------------------
module tb_wb_store_queue;

    localparam int W = 98;  // {addr[31:0], data[63:0], size[1:0]}

`ifdef WBSQ_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    wb_store_queue_if bus ();

    wb_store_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.dc_req === 1'b1 && bus.dc_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected none",
                         {bus.dc_addr, bus.dc_data, bus.dc_size});
            end else begin
                check("dc_write", {bus.dc_addr, bus.dc_data, bus.dc_size}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_size = s;
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s,
                        input bit accept);
        set_wr(a, d, s);
        bus.wr_en = 1'b1;
        if (accept) exp_q.push_back({a, d, s});
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.dc_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("wait_dc_req", bus.dc_req, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_size  = '0;
        bus.dc_ack   = 1'b0;
        bus.fwd_addr = '0;

        repeat (2) step();
        rst = 1'b0;

        // Reset state
        check("rst_dc_req", bus.dc_req, 1'b0);
        check("rst_full",   bus.full,   1'b0);
        check("rst_empty",  bus.empty,  1'b1);
        check("rst_count",  bus.count,  4'd0);
        check("rst_ovf",    bus.ovf_err, 1'b0);
        check("rst_fwd",    bus.fwd_hit, 1'b0);

        // Single store held without ack
        push(32'h1000, 64'hAA, 2'b00, 1'b1);
        check("single_count", bus.count, 4'd1);
        step();
        check("single_dc_req", bus.dc_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_dc_addr", bus.dc_addr, 32'h1000);
            check("hold_dc_req",  bus.dc_req,  1'b1);
            check("hold_count",   bus.count,   4'd1);
            step();
        end
        bus.fwd_addr = 32'h1004;
        #1 check("fwd_same_block", bus.fwd_hit, FWD);
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("single_drained_empty", bus.empty,   1'b1);
        check("single_drained_req",   bus.dc_req,  1'b0);
        check("idle_dc_addr_zero",    bus.dc_addr, 32'h0);
        check("idle_dc_data_zero",    bus.dc_data, 64'h0);

        // Fill to full, then overflow
        push(32'h2004, 64'h1111_2222_3333_4444, 2'b11, 1'b1);
        push(32'h3000, 64'h55,                  2'b00, 1'b1);
        push(32'h3008, 64'h6677,                2'b01, 1'b1);
        push(32'h3010, 64'h8899_AABB,           2'b10, 1'b1);
        check("fill_full",    bus.full,    1'b1);
        check("fill_count",   bus.count,   4'd4);
        check("fill_dc_addr", bus.dc_addr, 32'h2004);
        bus.fwd_addr = 32'h2000;
        #1 check("fwd_hit_2000", bus.fwd_hit, FWD);
        bus.fwd_addr = 32'h2008;
        #1 check("fwd_miss_2008", bus.fwd_hit, 1'b0);
        push(32'h4000, 64'hDEAD, 2'b11, 1'b0);
        check("ovf_set",   bus.ovf_err, 1'b1);
        check("ovf_count", bus.count,   4'd4);
        repeat (2) step();
        check("ovf_sticky",       bus.ovf_err, 1'b1);
        check("ovf_head_kept",    bus.dc_addr, 32'h2004);

        // Drain full queue back-to-back
        bus.dc_ack = 1'b1;
        repeat (4) step();
        bus.dc_ack = 1'b0;
        check("drain_dc_req", bus.dc_req,  1'b0);
        check("drain_empty",  bus.empty,   1'b1);
        check("drain_count",  bus.count,   4'd0);
        check("drain_ovf",    bus.ovf_err, 1'b1);
        bus.fwd_addr = 32'h2000;
        #1 check("fwd_stale_entry", bus.fwd_hit, 1'b0);

        // Simultaneous push and pop, pointer wrap (7 pushes / 7 acks)
        push(32'h5000, 64'h01, 2'b00, 1'b1);
        push(32'h5008, 64'h02, 2'b01, 1'b1);
        check("pp_dc_req", bus.dc_req, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_wr(32'h6000 + 32'(i * 8), 64'h100 + 64'(i), 2'(i));
            exp_q.push_back({bus.wr_addr, bus.wr_data, bus.wr_size});
            bus.wr_en  = 1'b1;
            bus.dc_ack = 1'b1;
            step();
            check("pp_count", bus.count, 4'd2);
        end
        bus.wr_en = 1'b0;
        repeat (2) step();
        bus.dc_ack = 1'b0;
        check("pp_empty",  bus.empty,  1'b1);
        check("pp_dc_req_low", bus.dc_req, 1'b0);

        // Reset mid-request
        push(32'h7000, 64'hA1, 2'b00, 1'b1);
        push(32'h7008, 64'hA2, 2'b00, 1'b1);
        push(32'h7010, 64'hA3, 2'b00, 1'b1);
        push(32'h7018, 64'hA4, 2'b00, 1'b1);
        push(32'h7020, 64'hA5, 2'b00, 1'b0);  // overflow so reset must clear ovf_err
        check("pre_rst_ovf", bus.ovf_err, 1'b1);
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("pre_rst_count",  bus.count,  4'd3);
        check("pre_rst_dc_req", bus.dc_req, 1'b1);
        rst        = 1'b1;
        bus.dc_ack = 1'b1;
        set_wr(32'h7777, 64'h77, 2'b00);
        bus.wr_en  = 1'b1;
        step();
        rst        = 1'b0;
        bus.dc_ack = 1'b0;
        bus.wr_en  = 1'b0;
        exp_q.delete();
        check("post_rst_dc_req", bus.dc_req,  1'b0);
        check("post_rst_count",  bus.count,   4'd0);
        check("post_rst_empty",  bus.empty,   1'b1);
        check("post_rst_ovf",    bus.ovf_err, 1'b0);
        bus.fwd_addr = 32'h7000;
        #1 check("post_rst_fwd", bus.fwd_hit, 1'b0);

        // Queue still works after reset
        push(32'h8000, 64'hCAFE, 2'b01, 1'b1);
        wait_req();
        bus.dc_ack = 1'b1;
        step();
        bus.dc_ack = 1'b0;
        check("final_empty", bus.empty, 1'b1);
        step();
        check("scoreboard_drained", 98'(exp_q.size()), 98'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
